// File: rtl/ex_mem_branch_stage.sv
// ex_mem_branch_stage: EX/MEM pipeline register with beq/blt resolution,
// a one-cycle fetch redirect and a fixed-depth squash of wrong-path entries.
// Latency: 1 cycle EX->MEM. A stall holds all state except pc_src, which
// drops to 0. A flush inserts a bubble.
// Ports: clk/reset (sync, active-high); stall, flush; ex_* from the ALU stage;
//   mem_* to the MEM stage; pc_src/pc_target redirect; squashing status.
// Optional: define BRANCH_STATS_EN to add the taken_count/squash_count outputs.
module ex_mem_branch_stage #(
  parameter int XLEN         = 64,
  parameter int SQUASH_DEPTH = 2    // 1..7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_zero,
  input  logic            ex_lt_n,
  input  logic [2:0]      ex_func3,
  input  logic            ex_branch,
  input  logic [XLEN-1:0] ex_target,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            pc_src,
  output logic [XLEN-1:0] pc_target,
  output logic            squashing
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     taken_count,
  output logic [31:0]     squash_count
`endif
);

  localparam logic [2:0] SQ_INIT = 3'(SQUASH_DEPTH);

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t     state;
  logic [2:0] cnt;

  logic accept;
  logic br_cond;
  logic taken;
  logic capture;

  // The FSM is in SQUASH exactly when cnt is nonzero, so the state replaces a
  // cnt==0 compare on the accept path.
  assign accept  = ex_valid && (state == IDLE);
  assign br_cond = ((ex_func3 == 3'b000) && ex_zero) ||
                   ((ex_func3 == 3'b100) && !ex_lt_n);
  assign taken   = accept && ex_branch && br_cond;
  assign capture = !flush && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 3'd0;
      squashing      <= 1'b0;
      mem_valid      <= 1'b0;
      mem_result     <= '0;
      mem_store_data <= '0;
      mem_rd         <= 5'd0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      pc_src         <= 1'b0;
      pc_target      <= '0;
    end else if (flush) begin
      // Bubble: data fields hold, any local squash is abandoned.
      state          <= IDLE;
      cnt            <= 3'd0;
      squashing      <= 1'b0;
      mem_valid      <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      pc_src         <= 1'b0;
    end else if (stall) begin
      // The redirect is a strict one-cycle pulse; a stall never stretches it.
      pc_src <= 1'b0;
    end else begin
      mem_valid      <= accept;
      mem_result     <= ex_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
      // A taken branch travels down as a valid no-op: no register or memory write.
      mem_reg_write  <= accept && ex_reg_write && !taken;
      mem_mem_read   <= accept && ex_mem_read;
      mem_mem_write  <= accept && ex_mem_write && !taken;
      mem_mem_to_reg <= accept && ex_mem_to_reg;
      pc_src         <= taken;
      if (taken) begin
        pc_target <= ex_target;
      end

      case (state)
        IDLE: begin
          if (taken) begin
            state     <= SQUASH;
            cnt       <= SQ_INIT;
            squashing <= 1'b1;
          end
        end
        SQUASH: begin
          // Counts edges, not valid entries: a bubble from EX also uses up a slot.
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= IDLE;
            squashing <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 3'd0;
          squashing <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  logic drop;
  assign drop = capture && ex_valid && (state == SQUASH);

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count  <= 32'd0;
      squash_count <= 32'd0;
    end else begin
      if (capture && taken && (taken_count != 32'hFFFF_FFFF)) begin
        taken_count <= taken_count + 32'd1;
      end
      if (drop && (squash_count != 32'hFFFF_FFFF)) begin
        squash_count <= squash_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/ex_mem_branch_stage.md
Name: ex_mem_branch_stage

Overview:
- EX/MEM pipeline register directly downstream of the 64-bit ALU in the sorting RISC-V core.
- Captures ALU result and flags, resolves beq/blt, and issues a one-cycle redirect pulse with branch target to the fetch stage.
- After a taken branch, squashes a fixed number of younger wrong-path instructions arriving from EX.
- Presents registered data and control to the MEM stage.

Parameters:
- XLEN, 64, datapath width of result, store data and branch target.
- SQUASH_DEPTH, 2, younger EX entries discarded after a taken branch (1..7).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all stage state
- flush  input  1  external flush; insert bubble
- ex_valid  input  1  EX holds a real instruction
- ex_result  input  XLEN  ALU result
- ex_zero  input  1  ALU zero flag; meaningful only when func3=000
- ex_lt_n  input  1  ALU less-than flag, active-low; 0 means a<b when func3=100
- ex_func3  input  3  instruction func3
- ex_branch  input  1  instruction is a conditional branch
- ex_target  input  XLEN  precomputed branch target
- ex_rd  input  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  input  1 each  control bits
- ex_store_data  input  XLEN  rs2 value for stores
- mem_valid  output  1  MEM entry valid
- mem_result, mem_store_data  output  XLEN  registered copies
- mem_rd  output  5  registered rd
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each  registered control; forced 0 when mem_valid=0
- pc_src  output  1  one-cycle redirect pulse
- pc_target  output  XLEN  redirect address; valid while pc_src=1
- squashing  output  1  high while squash counter is nonzero

Behaviour:
- Reset: clk and reset only; reset is synchronous, active-high. All outputs, squash counter and stats counters are 0 after the first rising edge with reset=1. Reset aborts any squash in progress.
- Priority per edge: reset > flush > stall > capture.
- Capture (no stall/flush):
  - Accept = ex_valid & (cnt==0).
  - mem_* <= ex_* and mem_valid <= accept.
  - Control outputs gated by accept.
  - Latency 1 cycle.
- Branch decision (combinational on EX inputs):
  - taken = accept & ex_branch & ((func3==000 & ex_zero) | (func3==100 & ~ex_lt_n)).
  - Any other func3 is never taken.
- Taken branch:
  - pc_src <= 1 and pc_target <= ex_target for exactly one cycle.
  - The pulse is never extended by stall.
  - cnt <= SQUASH_DEPTH.
  - The branch itself is written to MEM with mem_reg_write=0, mem_mem_write=0.
- Squash FSM:
  - IDLE (cnt=0) -> SQUASH on taken.
  - SQUASH: each non-stall edge drops the EX entry (mem_valid <= 0) and decrements cnt. At cnt=1 it returns to IDLE.
  - Stall freezes cnt.
  - A branch arriving while cnt!=0 is itself squashed and cannot redirect.
- Stall: all registers hold except pc_src, which clears to 0.
- Flush:
  - mem_valid and all control outputs <= 0, pc_src <= 0.
  - Data fields hold.
  - cnt <= 0 (external flush supersedes local squash).
- Simultaneous flush and taken branch: flush wins, no redirect.
- Simultaneous stall and taken branch in EX: nothing captured. The branch is re-evaluated on the first non-stall edge.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined:
  - Adds outputs taken_count and squash_count, 32 bits each.
  - taken_count increments on each pc_src assertion edge.
  - squash_count increments on each edge where a valid EX entry is dropped by the squash counter.
  - Both saturate at 0xFFFFFFFF and are cleared by reset only.
- Undefined: no such ports or logic.

Test Plan:
- Reset held 2 cycles with ex_valid=1, ex_result=0x1234 -> all outputs 0. First edge after release: mem_result=0x1234, mem_valid=1.
- beq: func3=000, ex_zero=1, ex_target=0x80, branch=1 -> next cycle pc_src=1, pc_target=0x80. Following cycle pc_src=0. Next 2 valid EX entries give mem_valid=0. Third is accepted.
- blt with ex_lt_n=1 (not less), func3=100 -> pc_src stays 0, no squash. With ex_lt_n=0 -> redirect.
- beq with ex_zero=1 but func3=001 -> not taken.
- Taken branch, then stall=1 for 3 cycles during squash -> cnt stays 2, squashing=1 throughout. Two more non-stall edges drop entries, then normal flow resumes.
- Taken branch and flush on the same edge -> pc_src=0, mem_valid=0, squashing=0. With BRANCH_STATS_EN, taken_count unchanged.
